// File: rtl/pln_mem_arbiter.sv
// rtl/pln_mem_arbiter.sv - single-port RAM arbiter for fetch, CPU data and DMA requesters
// Optional feature macro: PLN_ARB_RR_EN (round-robin arbitration; fixed priority dm > if > dma when undefined)
module pln_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch (read-only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // CPU data
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    // DMA / debug loader
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    // RAM port
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // requester IDs double as the round-robin search order
    localparam logic [1:0] ID_DM  = 2'd0;
    localparam logic [1:0] ID_IF  = 2'd1;
    localparam logic [1:0] ID_DMA = 2'd2;

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              win_valid;
    logic [1:0]        win_id;
    logic              grant;
    logic              in_done;

`ifdef PLN_ARB_RR_EN
    logic [1:0]        last_q, last_d;
    logic [2:0]        req_vec;
    logic [1:0]        cand;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == ID_DMA) ? ID_DM : id + 2'd1;
    endfunction

    // round-robin: search starts at the requester after the last one granted
    always_comb begin
        win_valid = 1'b0;
        win_id    = ID_DM;
        req_vec   = {dma_req, if_req, dm_req};
        cand      = next_id(last_q);
        for (int k = 0; k < 3; k++) begin
            if (!win_valid && req_vec[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
            cand = next_id(cand);
        end
    end
`else
    // fixed priority dm > if > dma; dma may starve under continuous dm/if traffic
    always_comb begin
        win_valid = 1'b1;
        win_id    = ID_DM;
        if (dm_req) begin
            win_id = ID_DM;
        end else if (if_req) begin
            win_id = ID_IF;
        end else if (dma_req) begin
            win_id = ID_DMA;
        end else begin
            win_valid = 1'b0;
        end
    end
`endif

    // grants only in IDLE; rst_n gating keeps gnt low while reset is asserted
    assign grant   = (state_q == S_IDLE) && rst_n && win_valid;
    assign dm_gnt  = grant && (win_id == ID_DM);
    assign if_gnt  = grant && (win_id == ID_IF);
    assign dma_gnt = grant && (win_id == ID_DMA);

    // next-state logic: capture the winning access, count RAM latency, complete
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef PLN_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = win_id;
                    state_d = S_ACCESS;
`ifdef PLN_ARB_RR_EN
                    last_d  = win_id;
`endif
                    unique case (win_id)
                        ID_DM: begin
                            we_d    = dm_we;
                            addr_d  = dm_addr;
                            wdata_d = dm_wdata;
                        end
                        ID_DMA: begin
                            we_d    = dma_we;
                            addr_d  = dma_addr;
                            wdata_d = dma_wdata;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and access registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            owner_q <= ID_DM;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef PLN_ARB_RR_EN
    // last-granted pointer resets to dma so the first search order is dm, if, dma
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ID_DMA;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign ram_en    = (state_q == S_ACCESS);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);

    // completion pulse to the owner; read data passes through only for reads
    assign in_done   = (state_q == S_DONE);
    assign dm_done   = in_done && (owner_q == ID_DM);
    assign if_done   = in_done && (owner_q == ID_IF);
    assign dma_done  = in_done && (owner_q == ID_DMA);
    assign dm_rdata  = (dm_done  && !we_q) ? ram_rdata : '0;
    assign if_rdata  = (if_done  && !we_q) ? ram_rdata : '0;
    assign dma_rdata = (dma_done && !we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_pln_mem_arbiter.sv
// tb/tb_pln_mem_arbiter.sv - self-checking bench for pln_mem_arbiter
module tb_pln_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        if_req = 0, dm_req = 0, dma_req = 0;
    logic        dm_we = 0, dma_we = 0;
    logic [15:0] if_addr = 0, dm_addr = 0, dma_addr = 0;
    logic [15:0] dm_wdata = 0, dma_wdata = 0;
    logic        if_gnt, dm_gnt, dma_gnt, if_done, dm_done, dma_done;
    logic [15:0] if_rdata, dm_rdata, dma_rdata;
    logic        ram_en, ram_we, busy;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;

    logic        if1_req = 0;
    logic [15:0] if1_addr = 16'h0010;
    logic        if1_gnt, if1_done, dm1_gnt, dm1_done, dma1_gnt, dma1_done;
    logic [15:0] if1_rdata, dm1_rdata, dma1_rdata;
    logic        ram1_en, ram1_we, busy1;
    logic [15:0] ram1_addr, ram1_wdata, ram1_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pln_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    pln_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_done(if1_done), .if_rdata(if1_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0), .dm_wdata(16'h0),
        .dm_gnt(dm1_gnt), .dm_done(dm1_done), .dm_rdata(dm1_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0), .dma_wdata(16'h0),
        .dma_gnt(dma1_gnt), .dma_done(dma1_done), .dma_rdata(dma1_rdata),
        .ram_en(ram1_en), .ram_we(ram1_we), .ram_addr(ram1_addr), .ram_wdata(ram1_wdata),
        .ram_rdata(ram1_rdata), .busy(busy1)
    );

    // RAM models: data valid exactly RD_LAT cycles after the enable cycle, 0xDEAD otherwise
    logic [15:0] mem [0:1023];
    logic [15:0] p0 = 0, p1 = 0, q0 = 0;
    logic        v0 = 0, v1 = 0, w0 = 0;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[16] = 16'hBEEF;
    end
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr[9:0]] <= ram_wdata;
        p0 <= mem[ram_addr[9:0]];
        v0 <= ram_en && !ram_we;
        p1 <= p0;
        v1 <= v0;
        q0 <= mem[ram1_addr[9:0]];
        w0 <= ram1_en;
    end
    assign ram_rdata  = v1 ? p1 : 16'hDEAD;
    assign ram1_rdata = w0 ? q0 : 16'hDEAD;

    typedef struct {
        int          who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        int          who;
        logic [15:0] rdata;
    } exp_t;

    vec_t vt[9];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic any_out();
        return |{dm_gnt, if_gnt, dma_gnt, dm_done, if_done, dma_done, dm_rdata, if_rdata,
                 dma_rdata, ram_en, ram_we, ram_addr, ram_wdata, busy};
    endfunction

    function automatic logic gnt_of(input int w);
        return (w == 0) ? dm_gnt : (w == 1) ? if_gnt : dma_gnt;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? dm_done : (w == 1) ? if_done : dma_done;
    endfunction

    function automatic logic [15:0] rdata_of(input int w);
        return (w == 0) ? dm_rdata : (w == 1) ? if_rdata : dma_rdata;
    endfunction

    function automatic logic [31:0] gnt_count();
        return 32'(dm_gnt) + 32'(if_gnt) + 32'(dma_gnt);
    endfunction

    function automatic logic [31:0] done_count();
        return 32'(dm_done) + 32'(if_done) + 32'(dma_done);
    endfunction

    task automatic drive_req(input int w, input logic v, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata);
        case (w)
            0: begin dm_req = v; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
            1: begin if_req = v; if_addr = addr; end
            default: begin dma_req = v; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        endcase
    endtask

    // one complete access, entered and left just after a falling edge
    task automatic do_access(input vec_t v);
        int   tg;
        bit   got;
        exp_t e;
        got = 0;
        tg  = 0;
        drive_req(v.who, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 0; k < 12; k++) begin
            #1;
            if (gnt_of(v.who)) begin
                got = 1;
                tg  = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("gnt_seen", 32'(got), 32'd1);
        if (!got) begin
            drive_req(v.who, 1'b0, 1'b0, 16'h0, 16'h0);
            return;
        end
        chk("gnt_onehot", gnt_count(), 32'd1);
        sbq.push_back('{who: v.who, rdata: v.rdata});
        @(posedge clk);
        #1;
        drive_req(v.who, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("access_ram_en", 32'(ram_en), 32'd1);
        chk("access_ram_addr", 32'(ram_addr), 32'(v.addr));
        chk("access_ram_we", 32'(ram_we), 32'(v.we));
        if (v.we) chk("access_ram_wdata", 32'(ram_wdata), 32'(v.wdata));
        @(negedge clk);
        chk("wait_ram_en_we", 32'({ram_en, ram_we}), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_count() != 0) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("done_cycle", 32'(cyc - tg), 32'd3);
            chk("done_onehot_owner", 32'(done_of(v.who)), 32'd1);
            chk("done_count", done_count(), 32'd1);
            chk("done_ram_we", 32'(ram_we), 32'd0);
            if (sbq.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("sb_owner", 32'(v.who), 32'(e.who));
                chk("done_rdata", 32'(rdata_of(e.who)), 32'(e.rdata));
                chk("nonowner_rdata", 32'((dm_rdata | if_rdata | dma_rdata) & ~rdata_of(e.who)), 32'd0);
            end
        end
        @(negedge clk);
        chk("busy_idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int          gw[4];
        int          gc[4];
        int          n;
        int          tg;
        bit          got;
        bit          saw_done;

        vt[0] = '{who: 1, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'hBEEF};
        vt[1] = '{who: 0, we: 1'b1, addr: 16'h0200, wdata: 16'h1234, rdata: 16'h0000};
        vt[2] = '{who: 0, we: 1'b0, addr: 16'h0200, wdata: 16'h0000, rdata: 16'h1234};
        vt[3] = '{who: 2, we: 1'b1, addr: 16'h0033, wdata: 16'hA5A5, rdata: 16'h0000};
        vt[4] = '{who: 1, we: 1'b0, addr: 16'h0033, wdata: 16'h0000, rdata: 16'hA5A5};
        vt[5] = '{who: 2, we: 1'b0, addr: 16'h0200, wdata: 16'h0000, rdata: 16'h1234};
        vt[6] = '{who: 0, we: 1'b1, addr: 16'h03FF, wdata: 16'hFFFF, rdata: 16'h0000};
        vt[7] = '{who: 2, we: 1'b0, addr: 16'h03FF, wdata: 16'h0000, rdata: 16'hFFFF};
        vt[8] = '{who: 1, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, rdata: 16'h0000};

        // reset state, with a request pending to prove gnt stays low
        @(negedge clk);
        if_req = 1'b1;
        #1;
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        chk("reset_lat1_outputs_zero", 32'({if1_gnt, if1_done, ram1_en, busy1}), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) do_access(vt[i]);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // all three requesting from reset
        rst_n = 1'b0;
        drive_req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        drive_req(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        drive_req(2, 1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        chk("reset_reqs_outputs_zero", 32'(any_out()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (gnt_count() != 0) begin
                chk("multi_gnt_onehot", gnt_count(), 32'd1);
                gw[n] = dm_gnt ? 0 : if_gnt ? 1 : 2;
                gc[n] = cyc;
                n++;
            end
            if (n == 4) break;
            @(negedge clk);
        end
        chk("multi_gnt_count", 32'(n), 32'd4);
        if (n == 4) begin
`ifdef PLN_ARB_RR_EN
            chk("rr_order0", 32'(gw[0]), 32'd0);
            chk("rr_order1", 32'(gw[1]), 32'd1);
            chk("rr_order2", 32'(gw[2]), 32'd2);
            chk("rr_order3", 32'(gw[3]), 32'd0);
`else
            chk("fp_order0", 32'(gw[0]), 32'd0);
            chk("fp_order1", 32'(gw[1]), 32'd0);
            chk("fp_order2", 32'(gw[2]), 32'd0);
            chk("fp_order3", 32'(gw[3]), 32'd0);
`endif
            chk("multi_spacing1", 32'(gc[1] - gc[0]), 32'd4);
            chk("multi_spacing2", 32'(gc[2] - gc[1]), 32'd4);
            chk("multi_spacing3", 32'(gc[3] - gc[2]), 32'd4);
        end
        @(posedge clk);
        #1;
`ifndef PLN_ARB_RR_EN
        dm_req = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (gnt_count() != 0) begin
                got = 1;
                break;
            end
        end
        chk("fp_if_after_dm_drop", 32'(got && if_gnt), 32'd1);
        chk("fp_if_after_dm_cycle", 32'(cyc - gc[3]), 32'd4);
        @(posedge clk);
        #1;
`endif
        drive_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("multi_back_idle", 32'(busy), 32'd0);

        // reset during WAIT of a dma read
        drive_req(2, 1'b1, 1'b0, 16'h0033, 16'h0);
        got = 0;
        tg  = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (dma_gnt) begin
                got = 1;
                tg  = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("rst_dma_gnt", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs_zero", 32'(any_out()), 32'd0);
        saw_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dma_done) saw_done = 1;
        end
        chk("rst_no_dma_done", 32'(saw_done), 32'd0);
        chk("rst_held_outputs_zero", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_dma_gnt", 32'(dma_gnt), 32'd1);
        tg = cyc;
        @(posedge clk);
        #1;
        dma_req = 1'b0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dma_done) begin
                got = 1;
                break;
            end
        end
        chk("rst_rerequest_done", 32'(got), 32'd1);
        chk("rst_rerequest_cycle", 32'(cyc - tg), 32'd3);
        chk("rst_rerequest_rdata", 32'(dma_rdata), 32'h0000A5A5);
        @(negedge clk);

        // RD_LAT=1: done at T+2, next gnt at T+3 with the request held
        if1_req = 1'b1;
        got = 0;
        tg  = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (if1_gnt) begin
                got = 1;
                tg  = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("lat1_gnt", 32'(got), 32'd1);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if1_done) begin
                got = 1;
                break;
            end
        end
        chk("lat1_done_seen", 32'(got), 32'd1);
        chk("lat1_done_cycle", 32'(cyc - tg), 32'd2);
        chk("lat1_rdata", 32'(if1_rdata), 32'h0000BEEF);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (if1_gnt) begin
                got = 1;
                break;
            end
        end
        chk("lat1_next_gnt_cycle", 32'(got ? cyc - tg : 0), 32'd3);
        @(posedge clk);
        #1;
        if1_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        chk("lat1_back_idle", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
